sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Successive-approximation controller that sequences the on-chip comparator stage (Vip/Vin → Out) as the decision element of an N-bit SAR ADC. It owns the sample phase, drives a trial code to the external DAC, waits for settling, samples the comparator and resolves one bit per step. It sits between the top-level `ui_in`/`uo_out` pins and the comparator datapath, and is the only block that sequences it.

## Interface
- `WIDTH`, 8: conversion resolution in bits (2..12).
- `SAMPLE_CYC`, 4: cycles the sample/hold switch is closed (≥1).
- `SETTLE_CYC`, 2: DAC settle cycles before each comparator decision (≥1).

- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset; asynchronous and active-low.
- `start_i` input 1: conversion request, level-sampled; only acted on in IDLE.
- `abort_i` input 1: cancel the conversion in progress; no result is produced.
- `cmp_i` input 1: comparator output; 1 = analog input ≥ DAC level.
- `sample_o` output 1: sample/hold switch enable.
- `dac_code_o` output WIDTH: trial code to the DAC.
- `busy_o` output 1: high in SAMPLE, SETTLE and DECIDE.
- `valid_o` output 1: one-cycle pulse; `result_o` is new.
- `result_o` output WIDTH: last completed conversion, held until the next completion.

## Operation
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE: `start_i`=1 and `abort_i`=0 → SAMPLE. Clear the working register and load the bit pointer with WIDTH-1.
- SAMPLE: `sample_o`=1 for SAMPLE_CYC cycles → SETTLE.
- SETTLE: `dac_code_o` = working | (1<<ptr). Hold for SETTLE_CYC cycles → DECIDE.
- DECIDE: one cycle. Sample `cmp_i`. If 1, keep the trial bit; if 0, clear it. If ptr==0 → DONE, else decrement ptr → SETTLE.
- DONE: load `result_o` from the working register and assert `valid_o` for one cycle → IDLE.
- `abort_i`=1 in SAMPLE/SETTLE/DECIDE → IDLE on the next edge. No `valid_o`. `result_o` is unchanged. `dac_code_o` returns to 0.
- In IDLE, `abort_i` takes priority over `start_i`.
- `start_i` in any state other than IDLE is ignored. It is not queued.
- `dac_code_o` is 0 in IDLE, SAMPLE and DONE.
- All arithmetic is unsigned, WIDTH bits. No wrap is possible because ptr stops at 0.

## Timing
- Reset values: state IDLE; `sample_o`=0, `dac_code_o`=0, `busy_o`=0, `valid_o`=0, `result_o`=0.
- Reset asserted mid-conversion gives the reset values immediately, with no `valid_o`.
- `start_i` is seen at edge E0. `busy_o` goes high after E0. DONE, with `valid_o` high, is entered at edge E0 + SAMPLE_CYC + WIDTH·(SETTLE_CYC+1).
- With the defaults, DONE is entered 28 edges after E0.
- The earliest next start is the edge after DONE, giving back-to-back conversions every L+2 cycles.
- `cmp_i` is used only on the DECIDE edge.

## Configuration
- `SAR_CMP_SYNC_EN` defined:
  - A 2-flop synchronizer is inserted on `cmp_i`.
  - SETTLE lasts SETTLE_CYC+2 cycles, so the decision sees the synchronized value for the current trial.
  - Latency is SAMPLE_CYC + WIDTH·(SETTLE_CYC+3). With the defaults this is 44.
- Undefined: `cmp_i` is used directly. It must be synchronous to `clk`.

## Structure
- `sar_ctrl_pkg` holds:
  - the state enum;
  - default constants for WIDTH, SAMPLE_CYC and SETTLE_CYC;
  - the function that computes latency from the parameters.
- Sub-module `sar_phase_timer` is a loadable down-counter with a `zero` flag. One instance is shared by the SAMPLE and SETTLE phases.

## Test plan
- Model `cmp_i` = (0xA5 ≥ `dac_code_o`). Pulse start → `valid_o` at E0+28, `result_o`=0xA5. Trial codes are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Model inputs 0x00 and 0xFF → results 0x00 and 0xFF. `busy_o` is high for exactly 28 cycles.
- Assert `abort_i` at cycle 10 of a conversion → IDLE next cycle, no `valid_o`, `result_o` keeps the previous 0xA5.
- Hold `start_i` high continuously → conversions complete every 30 cycles. Extra start pulses while busy cause no restart.
- Deassert `rst_n` mid-SETTLE → all outputs reach their reset values asynchronously. After release, a new start converts correctly.
- With `SAR_CMP_SYNC_EN` defined, repeat the 0xA5 case → `valid_o` at E0+44, result 0xA5.

Source files
------------

// File: rtl/sar_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl_pkg
// Description : Shared types, default constants and latency helper for the
//               SAR ADC controller. Honours SAR_CMP_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_ctrl_pkg;

    // Controller phases
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_t;

    localparam int c_default_width      = 8;
    localparam int c_default_sample_cyc = 4;
    localparam int c_default_settle_cyc = 2;

    // Edges from the start edge to the edge that enters DONE
    function automatic int sar_latency(input int width, input int sample_cyc,
                                       input int settle_cyc);
`ifdef SAR_CMP_SYNC_EN
        return sample_cyc + width * (settle_cyc + 3);
`else
        return sample_cyc + width * (settle_cyc + 1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : sar_phase_timer
// Description : Loadable down-counter with a zero flag; times the sample and
//               settle phases of the SAR controller.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation controller: sample phase, trial-code
//               generation, settle wait and one bit decision per step.
//               Optional macro SAR_CMP_SYNC_EN adds a 2-flop comparator
//               synchronizer and lengthens each settle phase by two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int SAMPLE_CYC = c_default_sample_cyc,
    parameter int SETTLE_CYC = c_default_settle_cyc
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cmp_i,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

`ifdef SAR_CMP_SYNC_EN
    // Two extra settle cycles let the synchronized decision catch up
    localparam int c_settle_load = SETTLE_CYC + 1;
`else
    localparam int c_settle_load = SETTLE_CYC - 1;
`endif
    localparam int c_sample_load = SAMPLE_CYC - 1;
    localparam int c_cnt_max = (c_sample_load > c_settle_load) ? c_sample_load : c_settle_load;
    localparam int c_cnt_w   = (c_cnt_max < 2) ? 1 : $clog2(c_cnt_max + 1);
    localparam int c_ptr_w   = $clog2(WIDTH);

    sar_state_t         r_state;
    logic [WIDTH-1:0]   r_work;
    logic [c_ptr_w-1:0] r_ptr;
    logic               w_cmp;
    logic               w_tmr_load;
    logic [c_cnt_w-1:0] w_tmr_val;
    logic               w_tmr_zero;
    logic [WIDTH-1:0]   w_trial_bit;
    logic [WIDTH-1:0]   w_work_next;

`ifdef SAR_CMP_SYNC_EN
    logic r_cmp_meta;
    logic r_cmp_sync;

    // Two-stage synchronizer for an asynchronous comparator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_meta <= 1'b0;
            r_cmp_sync <= 1'b0;
        end else begin
            r_cmp_meta <= cmp_i;
            r_cmp_sync <= r_cmp_meta;
        end
    end

    assign w_cmp = r_cmp_sync;
`else
    assign w_cmp = cmp_i;
`endif

    assign w_trial_bit = WIDTH'(1) << r_ptr;
    assign w_work_next = w_cmp ? (r_work | w_trial_bit) : r_work;

    // Reload the shared phase timer on every transition into SAMPLE or SETTLE
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_cnt_w'(c_sample_load);
                end
            end
            ST_SAMPLE: begin
                if (w_tmr_zero && !abort_i) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_cnt_w'(c_settle_load);
                end
            end
            ST_DECIDE: begin
                if (r_ptr != '0 && !abort_i) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_cnt_w'(c_settle_load);
                end
            end
            default: ;
        endcase
    end

    sar_phase_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .zero     (w_tmr_zero)
    );

    // Conversion sequencer with registered outputs; abort wins in active phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_ptr      <= '0;
            sample_o   <= 1'b0;
            dac_code_o <= '0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            result_o   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (abort_i && (r_state == ST_SAMPLE || r_state == ST_SETTLE ||
                            r_state == ST_DECIDE)) begin
                r_state    <= ST_IDLE;
                sample_o   <= 1'b0;
                dac_code_o <= '0;
                busy_o     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            r_state  <= ST_SAMPLE;
                            r_work   <= '0;
                            r_ptr    <= c_ptr_w'(WIDTH - 1);
                            sample_o <= 1'b1;
                            busy_o   <= 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (w_tmr_zero) begin
                            r_state    <= ST_SETTLE;
                            sample_o   <= 1'b0;
                            dac_code_o <= r_work | w_trial_bit;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_tmr_zero) begin
                            r_state <= ST_DECIDE;
                        end
                    end
                    ST_DECIDE: begin
                        r_work <= w_work_next;
                        if (r_ptr == '0) begin
                            r_state    <= ST_DONE;
                            result_o   <= w_work_next;
                            valid_o    <= 1'b1;
                            busy_o     <= 1'b0;
                            dac_code_o <= '0;
                        end else begin
                            r_ptr      <= r_ptr - 1'b1;
                            r_state    <= ST_SETTLE;
                            dac_code_o <= w_work_next | (w_trial_bit >> 1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_adc_ctrl
// Description : Self-checking bench for sar_adc_ctrl with an ideal comparator
//               model and a result scoreboard. Honours SAR_CMP_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

`ifdef SAR_CMP_SYNC_EN
    localparam int c_lat = 4 + 8 * (2 + 3);
`else
    localparam int c_lat = 4 + 8 * (2 + 1);
`endif

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       abort_i;
    logic       cmp_i;
    logic       sample_o;
    logic [7:0] dac_code_o;
    logic       busy_o;
    logic       valid_o;
    logic [7:0] result_o;

    logic [7:0] vin;
    logic [7:0] prev_dac;
    int         cyc;
    int         n_cmp;
    int         n_err;
    logic [7:0] sb[$];
    logic [7:0] trials[$];

    sar_adc_ctrl #(
        .WIDTH      (8),
        .SAMPLE_CYC (4),
        .SETTLE_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cmp_i      (cmp_i),
        .sample_o   (sample_o),
        .dac_code_o (dac_code_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    // Ideal comparator on the analog input
    assign cmp_i = (vin >= dac_code_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        logic [7:0] exp_res;
        if (rst_n && valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_res = sb.pop_front();
                chk("result", {24'd0, result_o}, {24'd0, exp_res});
            end
        end
        if (dac_code_o != prev_dac && dac_code_o != 8'd0)
            trials.push_back(dac_code_o);
        prev_dac <= dac_code_o;
    end

    task automatic run_conv(input logic [7:0] v, output int lat, output int busy_cnt);
        int e0;
        bit got;
        @(negedge clk);
        vin = v;
        start_i = 1'b1;
        sb.push_back(v);
        trials.delete();
        e0 = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            if (busy_o) busy_cnt++;
            if (valid_o) begin
                got = 1'b1;
                lat = cyc - e0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk("conv_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int bcnt;
        int e0;
        int nv;
        int tv[3];
        logic [7:0] exp_tr[8];

        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        vin = 8'h00;
        prev_dac = 8'h00;
        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        repeat (3) @(negedge clk);
        chk("rst_sample", {31'd0, sample_o}, 32'd0);
        chk("rst_dac", {24'd0, dac_code_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_result", {24'd0, result_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Endpoint codes
        run_conv(8'h00, lat, bcnt);
        chk("lat_00", lat, c_lat);
        chk("busy_00", bcnt, c_lat);
        run_conv(8'hFF, lat, bcnt);
        chk("lat_FF", lat, c_lat);
        chk("busy_FF", bcnt, c_lat);

        // Reference code with full trial sequence
        run_conv(8'hA5, lat, bcnt);
        chk("lat_A5", lat, c_lat);
        chk("busy_A5", bcnt, c_lat);
        chk("trial_count", trials.size(), 8);
        for (int i = 0; i < 8 && i < trials.size(); i++)
            chk($sformatf("trial_%0d", i), {24'd0, trials[i]}, {24'd0, exp_tr[i]});

        // Abort at cycle 10 of a conversion
        @(negedge clk);
        vin = 8'h33;
        start_i = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_dac", {24'd0, dac_code_o}, 32'd0);
        chk("abort_sample", {31'd0, sample_o}, 32'd0);
        repeat (60) @(negedge clk);
        chk("abort_result", {24'd0, result_o}, 32'h0000_00A5);

        // Start held high: back-to-back conversions
        @(negedge clk);
        vin = 8'h5A;
        start_i = 1'b1;
        repeat (3) sb.push_back(8'h5A);
        nv = 0;
        for (int i = 0; i < 400 && nv < 3; i++) begin
            @(negedge clk);
            if (valid_o) begin
                tv[nv] = cyc;
                nv++;
            end
        end
        start_i = 1'b0;
        chk("held_count", nv, 3);
        if (nv == 3) begin
            chk("held_period_1", tv[1] - tv[0], c_lat + 2);
            chk("held_period_2", tv[2] - tv[1], c_lat + 2);
        end
        repeat (5) @(negedge clk);
        chk("held_idle", {31'd0, busy_o}, 32'd0);

        // Extra start pulses while busy must not restart or queue
        @(negedge clk);
        vin = 8'hC3;
        start_i = 1'b1;
        sb.push_back(8'hC3);
        e0 = cyc + 1;
        lat = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            start_i = (i == 5 || i == 15) ? 1'b1 : 1'b0;
            if (valid_o) lat = cyc - e0;
        end
        start_i = 1'b0;
        chk("pulse_lat", lat, c_lat);
        repeat (5) @(negedge clk);
        chk("pulse_no_restart", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset mid-SETTLE
        @(negedge clk);
        vin = 8'h77;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        chk("pre_rst_dac", {24'd0, dac_code_o}, 32'h0000_0080);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", {31'd0, sample_o}, 32'd0);
        chk("arst_dac", {24'd0, dac_code_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_result", {24'd0, result_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(8'h3C, lat, bcnt);
        chk("post_rst_lat", lat, c_lat);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
